egress_wrr_scheduler: RTL and testbench
=======================================

# egress_wrr_scheduler

Packet-atomic weighted round-robin scheduler for the NIC port egress. It drains the two egress queues, link-sourced and p2p-sourced, into a single transmit stream toward the HPC tx interface. Per-queue weights and a strict-priority override come from one rw register word. A packet is never interleaved with another packet.

## Interface
Parameters:
- ENTRY_WIDTH, 288, queue entry width. Bit ENTRY_WIDTH-1 = start, ENTRY_WIDTH-2 = end, remaining bits are opaque payload passed through unchanged.
- CNT_WIDTH, 32, width of the per-queue packet counters.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- rw_data  in  32  [7:0] weight q0 (link), [15:8] weight q1 (p2p), [16] strict priority q0, [31:17] reserved
- i_q0_empty  in  1  link FIFO empty (FWFT)
- iv_q0_dout  in  ENTRY_WIDTH  link FIFO head
- o_q0_rd_en  out  1  link FIFO pop
- i_q1_empty  in  1  p2p FIFO empty (FWFT)
- iv_q1_dout  in  ENTRY_WIDTH  p2p FIFO head
- o_q1_rd_en  out  1  p2p FIFO pop
- o_tx_valid  out  1  output entry valid
- ov_tx_data  out  ENTRY_WIDTH  output entry
- i_tx_ready  in  1  downstream accept
- ov_q0_pkt_cnt  out  CNT_WIDTH  packets forwarded from q0
- ov_q1_pkt_cnt  out  CNT_WIDTH  packets forwarded from q1
- o_framing_err  out  1  sticky; first entry of a packet lacked start

## Operation
- State machine: IDLE, SEND_Q0, SEND_Q1.
- IDLE: select a non-empty queue.
  - strict bit = 1: q0 always wins when non-empty.
  - Otherwise the current turn owner wins if non-empty, else the other queue.
  - Grant and first pop happen in the same cycle.
- SEND_Qx: pop qx whenever !i_qx_empty and the output slot is free (!o_tx_valid | i_tx_ready). When an entry with end=1 is popped:
  - increment ov_qx_pkt_cnt, which wraps modulo 2^CNT_WIDTH;
  - decrement the turn credit;
  - return to IDLE.
- Turn credit: loaded with weight of the owner on turn change; weight 0 is treated as 1.
  - When credit reaches 0 after a packet, ownership passes to the other queue.
  - If the owner is empty in IDLE and the other queue wins, ownership and credit switch to the winner.
- Queue empty mid-packet: stay in SEND_Qx and stall; no switch.
- A single-entry packet (start=1, end=1) completes in one pop.
- First popped entry of a packet with start=0: set o_framing_err (cleared only by reset); forward the entry anyway.
- At most one of o_q0_rd_en / o_q1_rd_en is high in any cycle.
- rw_data is sampled only in IDLE at turn change. Mid-turn writes take effect at the next turn.

## Timing
- Reset values: o_tx_valid 0, ov_tx_data 0, rd_en 0, counters 0, o_framing_err 0, state IDLE, owner q0, credit 0.
- Output is a one-deep register. A popped entry appears on ov_tx_data the cycle after rd_en.
- Empty-to-valid latency: 1 cycle.
- Throughput: one entry per cycle while i_tx_ready = 1.
- Packet boundary costs no bubble: the end pop and IDLE decision are combined. IDLE grants combinationally, so back-to-back packets stream at full rate.
- o_tx_valid/ov_tx_data hold stable while i_tx_ready = 0.
- Counter update is visible the cycle after the end pop.
- Reset asserted mid-packet: all outputs return to reset values immediately. The partial packet is discarded, and upstream FIFOs are reset in the same domain.

## Structure
- Shared header route_params_def.vh: entry start/end bit offsets, rw_data field offsets, state encodings.
- One sub-module, egress_out_slice: the one-deep valid/ready output register with async active-low reset.

## Test plan
- Reset then idle: both queues empty -> o_tx_valid = 0, rd_en = 0, counters 0.
- Weights q0 = 3, q1 = 1, strict = 0, both queues preloaded with 8 single-entry packets -> output order q0,q0,q0,q1 repeated; counters reach 8 each.
- Strict = 1, q1 four-entry packet in flight when q0 becomes non-empty -> q1 packet completes uninterrupted, then q0 served until empty.
- i_tx_ready toggled 1/0 every cycle on a 5-entry packet -> no entry lost or duplicated; data held stable while ready = 0.
- q0 empties after entry 2 of a 4-entry packet while q1 non-empty -> stall, no q1 pop until the q0 end entry arrives.
- Packet without start flag -> o_framing_err = 1 and stays set; async reset mid-packet -> all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/egress_wrr_scheduler_pkg.sv
// egress_wrr_scheduler_pkg: shared field offsets, state encoding and weight helper for the egress scheduler
package egress_wrr_scheduler_pkg;
  localparam int START_OFS = 1;
  localparam int END_OFS = 2;
  localparam int W0_LSB = 0;
  localparam int W1_LSB = 8;
  localparam int STRICT_BIT = 16;
  localparam int WEIGHT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_Q0 = 2'd1, SEND_Q1 = 2'd2} state_t;
  function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction
endpackage

// File: rtl/egress_out_slice.sv
// egress_out_slice: one-deep valid/ready output register with async active-low reset
module egress_out_slice #(
  parameter int WIDTH = 288
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (in_valid && in_ready) out_data <= in_data;
    end
  end
endmodule

// File: rtl/egress_wrr_scheduler.sv
// egress_wrr_scheduler: packet-atomic weighted round-robin drain of the link and p2p egress queues
module egress_wrr_scheduler
  import egress_wrr_scheduler_pkg::*;
#(
  parameter int ENTRY_WIDTH = 288,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            rw_data,
  input  logic                   i_q0_empty,
  input  logic [ENTRY_WIDTH-1:0] iv_q0_dout,
  output logic                   o_q0_rd_en,
  input  logic                   i_q1_empty,
  input  logic [ENTRY_WIDTH-1:0] iv_q1_dout,
  output logic                   o_q1_rd_en,
  output logic                   o_tx_valid,
  output logic [ENTRY_WIDTH-1:0] ov_tx_data,
  input  logic                   i_tx_ready,
  output logic [CNT_WIDTH-1:0]   ov_q0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]   ov_q1_pkt_cnt,
  output logic                   o_framing_err
);
  state_t state, state_nx;
  logic owner, owner_nx, slot_free, grant, grant_any, act, pop, is_end, fresh, unused_rw;
  logic [WEIGHT_WIDTH-1:0] credit, credit_nx, w_act, c_base, c_dec;
  logic [ENTRY_WIDTH-1:0] entry;
  assign unused_rw = ^rw_data[31:17];
  assign grant = (rw_data[STRICT_BIT] && !i_q0_empty) ? 1'b0 :
                 (owner ? !i_q1_empty : !i_q0_empty) ? owner : !owner;
  assign grant_any = !(i_q0_empty && i_q1_empty);
  assign act = (state == SEND_Q1) || (state == IDLE && grant);
  // rst gates the pop so the FIFOs see no read while reset is held
  assign pop = rst && slot_free && (act ? !i_q1_empty : !i_q0_empty) && (state != IDLE || grant_any);
  assign entry = act ? iv_q1_dout : iv_q0_dout;
  assign is_end = entry[ENTRY_WIDTH-END_OFS];
  assign w_act = eff_weight(act ? rw_data[W1_LSB +: WEIGHT_WIDTH] : rw_data[W0_LSB +: WEIGHT_WIDTH]);
  // a fresh turn reloads credit from the live weights; credit 0 means the turn is spent
  assign fresh = (state == IDLE) && (act != owner || credit == '0);
  assign c_base = fresh ? w_act : credit;
  assign c_dec = c_base - WEIGHT_WIDTH'(1);
  assign o_q0_rd_en = pop && !act;
  assign o_q1_rd_en = pop && act;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    credit_nx = credit;
    if (pop) begin
      owner_nx = act;
      credit_nx = c_base;
      state_nx = act ? SEND_Q1 : SEND_Q0;
      if (is_end) begin
        state_nx = IDLE;
        owner_nx = (c_dec == '0) ? !act : act;
        credit_nx = c_dec;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      credit <= '0;
      ov_q0_pkt_cnt <= '0;
      ov_q1_pkt_cnt <= '0;
      o_framing_err <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      credit <= credit_nx;
      if (pop && is_end && !act) ov_q0_pkt_cnt <= ov_q0_pkt_cnt + CNT_WIDTH'(1);
      if (pop && is_end && act) ov_q1_pkt_cnt <= ov_q1_pkt_cnt + CNT_WIDTH'(1);
      if (pop && state == IDLE && !entry[ENTRY_WIDTH-START_OFS]) o_framing_err <= 1'b1;
    end
  end
  egress_out_slice #(.WIDTH(ENTRY_WIDTH)) u_out (
    .clk(clk),
    .rst(rst),
    .in_valid(pop),
    .in_data(entry),
    .in_ready(slot_free),
    .out_valid(o_tx_valid),
    .out_data(ov_tx_data),
    .out_ready(i_tx_ready)
  );
endmodule

// File: tb/tb_egress_wrr_scheduler.sv
// tb_egress_wrr_scheduler: table, hand-written and randomized checks of the egress WRR scheduler
module tb_egress_wrr_scheduler;
  localparam int EW = 288;
  localparam int CW = 32;
  typedef logic [EW-1:0] ent_t;
  typedef struct {
    int w0, w1, strict, n0, n1, len, rmode, c0, c1, np;
    logic [15:0] order;
  } vec_t;
  logic clk = 0, rst = 0, q0_empty = 1, q1_empty = 1, q0_rd_en, q1_rd_en;
  logic tx_valid, tx_ready = 1, ferr;
  logic [31:0] rw_data = 0;
  ent_t q0_dout = '0, q1_dout = '0, tx_data, held;
  logic [CW-1:0] cnt0, cnt1;
  ent_t fifo0[$], fifo1[$], src0[$], src1[$], got[$], exp_q[$];
  int len0[$], len1[$];
  bit ord_exp[$];
  vec_t tv[6];
  int errors = 0, checks = 0, rmode = 0, pops0 = 0, pops1 = 0, pid = 0;
  bit was_stalled = 0;

  egress_wrr_scheduler #(.ENTRY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rw_data(rw_data),
    .i_q0_empty(q0_empty), .iv_q0_dout(q0_dout), .o_q0_rd_en(q0_rd_en),
    .i_q1_empty(q1_empty), .iv_q1_dout(q1_dout), .o_q1_rd_en(q1_rd_en),
    .o_tx_valid(tx_valid), .ov_tx_data(tx_data), .i_tx_ready(tx_ready),
    .ov_q0_pkt_cnt(cnt0), .ov_q1_pkt_cnt(cnt1), .o_framing_err(ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic chk_ent(input string name, input ent_t a, input ent_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic ent_t mk(input bit s, input bit en, input bit q, input int p, input int b);
    ent_t e;
    e = '0;
    e[31:0] = $urandom;
    e[47:40] = b[7:0];
    e[55:48] = p[7:0];
    e[56] = q;
    e[EW-1] = s;
    e[EW-2] = en;
    return e;
  endfunction

  task automatic add_pkt(input bit q, input int len, input bit nostart = 0);
    ent_t e;
    pid++;
    for (int b = 0; b < len; b++) begin
      e = mk(b == 0 && !nostart, b == len - 1, q, pid, b);
      if (q) begin fifo1.push_back(e); src1.push_back(e); end
      else begin fifo0.push_back(e); src0.push_back(e); end
    end
    if (q) len1.push_back(len); else len0.push_back(len);
  endtask

  task automatic drive();
    q0_empty = (fifo0.size() == 0);
    q1_empty = (fifo1.size() == 0);
    q0_dout = q0_empty ? '0 : fifo0[0];
    q1_dout = q1_empty ? '0 : fifo1[0];
  endtask

  task automatic clear();
    fifo0.delete(); fifo1.delete(); src0.delete(); src1.delete();
    len0.delete(); len1.delete(); got.delete(); exp_q.delete(); ord_exp.delete();
    pops0 = 0; pops1 = 0; was_stalled = 0; tx_ready = 1;
    drive();
  endtask

  task automatic do_reset();
    rst = 0;
    clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
  endtask

  // one clock: drive heads, sample combinational pops and the output handshake, then pop the model FIFOs
  task automatic step();
    bit p0, p1;
    drive();
    tx_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~tx_ready : ($urandom_range(0, 3) != 0);
    #1;
    chk("one_rd_en", {63'b0, q0_rd_en && q1_rd_en}, 0);
    if (was_stalled) begin
      chk("hold_valid", {63'b0, tx_valid}, 1);
      chk_ent("hold_data", tx_data, held);
    end
    was_stalled = tx_valid && !tx_ready;
    held = tx_data;
    if (tx_valid && tx_ready) got.push_back(tx_data);
    p0 = q0_rd_en;
    p1 = q1_rd_en;
    @(posedge clk);
    #1;
    if (p0) begin void'(fifo0.pop_front()); pops0++; end
    if (p1) begin void'(fifo1.pop_front()); pops1++; end
  endtask

  task automatic run(input int maxc);
    int n = 0;
    do begin step(); n++; end
    while ((fifo0.size() != 0 || fifo1.size() != 0 || tx_valid) && n < maxc);
    chk("drained", fifo0.size() + fifo1.size() + {31'b0, tx_valid}, 0);
  endtask

  task automatic build_expected();
    int i0 = 0, i1 = 0, k0 = 0, k1 = 0;
    exp_q.delete();
    foreach (ord_exp[i]) begin
      if (ord_exp[i]) begin
        for (int b = 0; b < len1[k1]; b++) exp_q.push_back(src1[i1++]);
        k1++;
      end else begin
        for (int b = 0; b < len0[k0]; b++) exp_q.push_back(src0[i0++]);
        k0++;
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk_ent({tag, "_data"}, got[i], exp_q[i]);
  endtask

  // packet-level WRR: pick winner, reload credit on a new or spent turn, pass the turn when credit hits 0
  task automatic model_order(input int w0, input int w1, input bit strict);
    int n[2];
    int owner = 0, credit = 0, g;
    n[0] = len0.size();
    n[1] = len1.size();
    ord_exp.delete();
    while (n[0] + n[1] > 0) begin
      if (strict && n[0] > 0) g = 0;
      else if (n[owner] > 0) g = owner;
      else g = 1 - owner;
      if (g != owner || credit == 0) credit = (g == 0) ? ((w0 == 0) ? 1 : w0) : ((w1 == 0) ? 1 : w1);
      owner = g;
      ord_exp.push_back(g[0]);
      n[g]--;
      credit--;
      if (credit == 0) owner = 1 - owner;
    end
  endtask

  initial begin
    logic [15:0] go;
    int np;
    ent_t e2, e3;
    tv[0] = '{3, 1, 0, 8, 8, 1, 0, 8, 8, 16, 16'hFC88};
    tv[1] = '{0, 0, 0, 4, 4, 1, 2, 4, 4, 8, 16'h00AA};
    tv[2] = '{1, 5, 1, 3, 3, 2, 0, 3, 3, 6, 16'h0038};
    tv[3] = '{1, 2, 0, 3, 6, 1, 2, 3, 6, 9, 16'h01B6};
    tv[4] = '{2, 2, 0, 0, 3, 3, 0, 0, 3, 3, 16'h0007};
    tv[5] = '{1, 1, 0, 1, 0, 5, 1, 1, 0, 1, 16'h0000};

    do_reset();
    repeat (3) step();
    chk("idle_valid", {63'b0, tx_valid}, 0);
    chk("idle_rd0", {63'b0, q0_rd_en}, 0);
    chk("idle_rd1", {63'b0, q1_rd_en}, 0);
    chk("idle_cnt0", cnt0, 0);
    chk("idle_cnt1", cnt1, 0);
    chk("idle_ferr", {63'b0, ferr}, 0);

    foreach (tv[v]) begin
      do_reset();
      rw_data = {15'b0, tv[v].strict[0], tv[v].w1[7:0], tv[v].w0[7:0]};
      for (int i = 0; i < tv[v].n0; i++) add_pkt(0, tv[v].len);
      for (int i = 0; i < tv[v].n1; i++) add_pkt(1, tv[v].len);
      rmode = tv[v].rmode;
      run(2000);
      rmode = 0;
      for (int i = 0; i < tv[v].np; i++) ord_exp.push_back(tv[v].order[i]);
      build_expected();
      compare_stream("tbl");
      go = '0;
      np = 0;
      foreach (got[i]) if (got[i][EW-1]) begin
        if (np < 16) go[np] = got[i][56];
        np++;
      end
      chk("tbl_order", go, tv[v].order);
      chk("tbl_npkt", np, tv[v].np);
      chk("tbl_cnt0", cnt0, tv[v].c0);
      chk("tbl_cnt1", cnt1, tv[v].c1);
    end

    do_reset();
    rw_data = 32'h0001_0101;
    add_pkt(1, 4);
    step();
    step();
    add_pkt(0, 1);
    add_pkt(0, 1);
    run(200);
    ord_exp = '{1'b1, 1'b0, 1'b0};
    build_expected();
    compare_stream("strict");

    do_reset();
    rw_data = 32'h0000_0101;
    add_pkt(0, 4);
    e3 = fifo0.pop_back();
    e2 = fifo0.pop_back();
    add_pkt(1, 2);
    repeat (6) step();
    chk("stall_q1_pops", pops1, 0);
    chk("stall_q0_pops", pops0, 2);
    fifo0.push_back(e2);
    fifo0.push_back(e3);
    run(200);
    ord_exp = '{1'b0, 1'b1};
    build_expected();
    compare_stream("stall");
    chk("stall_cnt0", cnt0, 1);
    chk("stall_cnt1", cnt1, 1);

    do_reset();
    add_pkt(0, 1, 1);
    run(100);
    chk("ferr_set", {63'b0, ferr}, 1);
    add_pkt(0, 2);
    run(100);
    chk("ferr_sticky", {63'b0, ferr}, 1);
    chk("pre_rst_cnt0", cnt0, 2);
    add_pkt(0, 4);
    step();
    step();
    chk("mid_pkt_valid", {63'b0, tx_valid}, 1);
    #2 rst = 0;
    #1;
    chk("arst_valid", {63'b0, tx_valid}, 0);
    chk("arst_data", tx_data[63:0] | {63'b0, |tx_data}, 0);
    chk("arst_rd0", {63'b0, q0_rd_en}, 0);
    chk("arst_rd1", {63'b0, q1_rd_en}, 0);
    chk("arst_cnt0", cnt0, 0);
    chk("arst_cnt1", cnt1, 0);
    chk("arst_ferr", {63'b0, ferr}, 0);
    clear();
    @(posedge clk);
    #1 rst = 1;

    for (int it = 0; it < 10; it++) begin
      int w0, w1, n0, n1;
      bit st;
      do_reset();
      w0 = $urandom_range(0, 3);
      w1 = $urandom_range(0, 3);
      st = ($urandom_range(0, 3) == 0);
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      rw_data = {$urandom_range(0, 32767), st, w1[7:0], w0[7:0]};
      for (int i = 0; i < n0; i++) add_pkt(0, $urandom_range(1, 4));
      for (int i = 0; i < n1; i++) add_pkt(1, $urandom_range(1, 4));
      rmode = 2;
      run(2000);
      rmode = 0;
      model_order(w0, w1, st);
      build_expected();
      compare_stream("rnd");
      chk("rnd_cnt0", cnt0, n0);
      chk("rnd_cnt1", cnt1, n1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
